deinterleaver_1: RTL and testbench

// - First-level (inverse first-permutation) bit deinterleaver, RX data field; sits directly downstream of the second-level deinterleaver.
// - Collects one OFDM symbol of NCBPS coded bits into a ping-pong bit buffer at permuted addresses, then streams them out in natural order.
// - Output feeds depuncturer/Viterbi; symbol count and Map_Type travel with each symbol.

---
 rtl/ofdm_rx_pkg.sv | 54 +++++
 rtl/deintv1_addr_gen.sv | 62 ++++++
 rtl/deinterleaver_1.sv | 135 +++++++++++++
 tb/tb_deinterleaver_1.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_pkg.sv
// ofdm_rx_pkg
// Shared constants and types for the OFDM RX bit-level blocks.
//   MAP_*      : Map_Type codes (BPSK/QPSK/16QAM/64QAM)
//   NCBPS_*    : coded bits per OFDM symbol for each Map_Type
//   NCOL_*     : first-permutation column count (NCBPS/16)
//   bank_state_e : ping-pong bank lifecycle EMPTY -> FILLING -> FULL -> EMPTY
package ofdm_rx_pkg;

  localparam int NCBPS_MAX = 288;

  localparam logic [1:0] MAP_BPSK  = 2'b00;
  localparam logic [1:0] MAP_QPSK  = 2'b01;
  localparam logic [1:0] MAP_QAM16 = 2'b10;
  localparam logic [1:0] MAP_QAM64 = 2'b11;

  localparam logic [8:0] NCBPS_BPSK  = 9'd48;
  localparam logic [8:0] NCBPS_QPSK  = 9'd96;
  localparam logic [8:0] NCBPS_QAM16 = 9'd192;
  localparam logic [8:0] NCBPS_QAM64 = 9'd288;

  localparam logic [4:0] NCOL_BPSK  = 5'd3;
  localparam logic [4:0] NCOL_QPSK  = 5'd6;
  localparam logic [4:0] NCOL_QAM16 = 5'd12;
  localparam logic [4:0] NCOL_QAM64 = 5'd18;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  function automatic logic [8:0] ncbps_of(input logic [1:0] map_type);
    logic [8:0] n;
    case (map_type)
      MAP_BPSK:  n = NCBPS_BPSK;
      MAP_QPSK:  n = NCBPS_QPSK;
      MAP_QAM16: n = NCBPS_QAM16;
      default:   n = NCBPS_QAM64;
    endcase
    return n;
  endfunction

  function automatic logic [4:0] ncol_of(input logic [1:0] map_type);
    logic [4:0] n;
    case (map_type)
      MAP_BPSK:  n = NCOL_BPSK;
      MAP_QPSK:  n = NCOL_QPSK;
      MAP_QAM16: n = NCOL_QAM16;
      default:   n = NCOL_QAM64;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/deintv1_addr_gen.sv
// deintv1_addr_gen
// Write-address generator for the first-level deinterleaver.
// Input bit j lands at k = 16*r + q with r = j mod NCOL, q = j / NCOL,
// tracked with two incremental counters (no multiply/divide).
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   adv_i         : a bit was accepted this cycle; step the counters
//   map_type_i    : Map_Type governing NCOL for the current symbol
//   k_o           : write address for the current bit
//   first_o       : current bit is j == 0
//   last_o        : current bit is j == NCBPS-1
module deintv1_addr_gen
  import ofdm_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv_i,
  input  logic [1:0] map_type_i,
  output logic [8:0] k_o,
  output logic       first_o,
  output logic       last_o
);

  logic [4:0] r_q, r_d;
  logic [3:0] q_q, q_d;
  logic [4:0] ncol;
  logic       r_wrap;

  assign ncol    = ncol_of(map_type_i);
  assign r_wrap  = (r_q == ncol - 5'd1);
  assign last_o  = r_wrap && (q_q == 4'd15);
  assign first_o = (r_q == 5'd0) && (q_q == 4'd0);
  // 16*r + q is a plain concatenation because q < 16.
  assign k_o     = {r_q, q_q};

  always_comb begin
    r_d = r_q;
    q_d = q_q;
    if (adv_i) begin
      if (last_o) begin
        r_d = 5'd0;
        q_d = 4'd0;
      end else if (r_wrap) begin
        r_d = 5'd0;
        q_d = q_q + 4'd1;
      end else begin
        r_d = r_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 5'd0;
      q_q <= 4'd0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/deinterleaver_1.sv
// deinterleaver_1
// First-level (inverse first-permutation) bit deinterleaver. One OFDM symbol
// of NCBPS bits is written into a ping-pong bank at permuted addresses, then
// read out in natural order together with the symbol's symb_cnt/Map_Type.
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high; once valid is asserted, data and tags stay stable until accepted.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   deintv1_din*           : interleaved-order input bit stream + tags
//   deintv1_dout*          : natural-order output bit stream + bank tags
module deinterleaver_1
  import ofdm_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       deintv1_din,
  input  logic       deintv1_din_vld,
  output logic       deintv1_din_rdy,
  input  logic [7:0] deintv1_din_symb_cnt,
  input  logic [1:0] deintv1_din_Map_Type,
  output logic       deintv1_dout,
  output logic       deintv1_dout_vld,
  input  logic       deintv1_dout_rdy,
  output logic [7:0] deintv1_dout_symb_cnt,
  output logic [1:0] deintv1_dout_Map_Type
);

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic [7:0]  tag_symb_q [2];
  logic [7:0]  tag_symb_d [2];
  logic [1:0]  tag_map_q [2];
  logic [1:0]  tag_map_d [2];
  logic        wr_sel_q, wr_sel_d;
  logic        rd_sel_q, rd_sel_d;
  logic [8:0]  rd_addr_q, rd_addr_d;
  logic        din_rdy_q, din_rdy_d;

  logic [NCBPS_MAX-1:0] mem_q [2];

  logic       wr_fire, wr_first, wr_last;
  logic [8:0] wr_k;
  logic [1:0] map_sel;
  logic       rd_vld, rd_fire, rd_last;

  assign wr_fire = deintv1_din_vld & din_rdy_q;
  // The bank tag is only written on j == 0, so that bit must take NCOL from
  // the live input; later bits use the latched tag and ignore input changes.
  assign map_sel = wr_first ? deintv1_din_Map_Type : tag_map_q[wr_sel_q];

  deintv1_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (wr_fire),
    .map_type_i (map_sel),
    .k_o        (wr_k),
    .first_o    (wr_first),
    .last_o     (wr_last)
  );

  assign rd_vld  = (bank_q[rd_sel_q] == BANK_FULL);
  assign rd_fire = rd_vld & deintv1_dout_rdy;
  assign rd_last = (rd_addr_q == ncbps_of(tag_map_q[rd_sel_q]) - 9'd1);

  always_comb begin
    bank_d     = bank_q;
    tag_symb_d = tag_symb_q;
    tag_map_d  = tag_map_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    rd_addr_d  = rd_addr_q;
    if (wr_fire) begin
      if (wr_first) begin
        bank_d[wr_sel_q]     = BANK_FILLING;
        tag_symb_d[wr_sel_q] = deintv1_din_symb_cnt;
        tag_map_d[wr_sel_q]  = deintv1_din_Map_Type;
      end
      if (wr_last) begin
        bank_d[wr_sel_q] = BANK_FULL;
        wr_sel_d         = ~wr_sel_q;
      end
    end
    // Read and write always target different banks (FULL vs not FULL), so
    // a simultaneous last-write and last-read both take effect here.
    if (rd_fire) begin
      if (rd_last) begin
        bank_d[rd_sel_q] = BANK_EMPTY;
        rd_addr_d        = 9'd0;
        rd_sel_d         = ~rd_sel_q;
      end else begin
        rd_addr_d = rd_addr_q + 9'd1;
      end
    end
    // Ready is registered from next-state, so a freed bank opens the input
    // on the following cycle.
    din_rdy_d = (bank_d[wr_sel_d] != BANK_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]     <= BANK_EMPTY;
      bank_q[1]     <= BANK_EMPTY;
      tag_symb_q[0] <= 8'd0;
      tag_symb_q[1] <= 8'd0;
      tag_map_q[0]  <= 2'b00;
      tag_map_q[1]  <= 2'b00;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      rd_addr_q     <= 9'd0;
      din_rdy_q     <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      tag_symb_q <= tag_symb_d;
      tag_map_q  <= tag_map_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      rd_addr_q  <= rd_addr_d;
      din_rdy_q  <= din_rdy_d;
    end
  end

  // Bit storage carries no reset; bank state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_sel_q][wr_k] <= deintv1_din;
    end
  end

  assign deintv1_din_rdy       = din_rdy_q;
  assign deintv1_dout_vld      = rd_vld;
  assign deintv1_dout          = rd_vld & mem_q[rd_sel_q][rd_addr_q];
  assign deintv1_dout_symb_cnt = tag_symb_q[rd_sel_q];
  assign deintv1_dout_Map_Type = tag_map_q[rd_sel_q];

endmodule

// File: tb/tb_deinterleaver_1.sv
module tb_deinterleaver_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din, din_vld, din_rdy;
  logic [7:0] din_symb_cnt;
  logic [1:0] din_Map_Type;
  logic       dout, dout_vld, dout_rdy;
  logic [7:0] dout_symb_cnt;
  logic [1:0] dout_Map_Type;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;     // 0: ready high, 1: random, 2: held low
  int stall_cnt = 0;
  bit hold_pend = 0;
  logic [10:0] held;

  logic [10:0] exp_q[$];  // {Map_Type, symb_cnt, bit}
  logic        cap_q[$];

  typedef struct {
    logic [1:0] map;
    int         one_j;
    int         exp_k;
  } vec_t;
  vec_t vecs[7];

  deinterleaver_1 dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .deintv1_din           (din),
    .deintv1_din_vld       (din_vld),
    .deintv1_din_rdy       (din_rdy),
    .deintv1_din_symb_cnt  (din_symb_cnt),
    .deintv1_din_Map_Type  (din_Map_Type),
    .deintv1_dout          (dout),
    .deintv1_dout_vld      (dout_vld),
    .deintv1_dout_rdy      (dout_rdy),
    .deintv1_dout_symb_cnt (dout_symb_cnt),
    .deintv1_dout_Map_Type (dout_Map_Type)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic int ncbps_tb(input logic [1:0] m);
    case (m)
      2'b00:   return 48;
      2'b01:   return 96;
      2'b10:   return 192;
      default: return 288;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // ---------------- downstream ready ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dout_rdy = 1'b1;
      1:       dout_rdy = 1'($urandom_range(0, 1));
      default: dout_rdy = 1'b0;
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (din_vld && !din_rdy && rst_n) stall_cnt++;
    if (hold_pend) begin
      check("dout_hold", {dout_vld, dout_Map_Type, dout_symb_cnt, dout}, {1'b1, held});
    end
    if (dout_vld && dout_rdy) begin
      if (exp_q.size() == 0) begin
        check("dout_extra", 32'd1, 32'd0);
      end else begin
        check("dout_stream", {dout_Map_Type, dout_symb_cnt, dout}, exp_q.pop_front());
      end
      cap_q.push_back(dout);
    end
    hold_pend = dout_vld && !dout_rdy;
    held      = {dout_Map_Type, dout_symb_cnt, dout};
  end

  // ---------------- driver ----------------
  // Reference model: bit j of the symbol appears at natural position
  // k = 16*(j mod NCOL) + j/NCOL; invert that to list outputs in k order.
  task automatic send_symbol(input logic [1:0] map, input logic [7:0] symb,
                             input logic [287:0] bits, input int nbits,
                             input bit gaps, input bit scramble, input bit push);
    int n, ncol, w, jj;
    n    = ncbps_tb(map);
    ncol = n / 16;
    if (push) begin
      for (int k = 0; k < n; k++) begin
        jj = (k % 16) * ncol + k / 16;
        exp_q.push_back({map, symb, bits[jj]});
      end
    end
    for (int j = 0; j < nbits; j++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      din          = bits[j];
      din_vld      = 1'b1;
      din_Map_Type = (scramble && j > 0) ? 2'($urandom_range(0, 3)) : map;
      din_symb_cnt = (scramble && j > 0) ? 8'($urandom) : symb;
      w = 0;
      @(negedge clk);
      while (!din_rdy) begin
        w++;
        if (w > 20000) timeout_abort("din_rdy_wait");
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      din_vld = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      w++;
      if (w > 20000) timeout_abort(name);
    end
    @(negedge clk);
    check({name, "_vld_after"}, dout_vld, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    hold_pend = 0;
    check("rst_dout_vld", dout_vld, 1'b0);
    check("rst_din_rdy", din_rdy, 1'b0);
    exp_q.delete();
    cap_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [287:0] rand_bits();
    logic [287:0] b;
    for (int j = 0; j < 288; j++) b[j] = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [287:0] bits;
    int ones, pos, total, n;
    logic [1:0] m;

    vecs[0] = '{2'b00, 1, 16};
    vecs[1] = '{2'b00, 0, 0};
    vecs[2] = '{2'b00, 47, 47};
    vecs[3] = '{2'b01, 7, 17};
    vecs[4] = '{2'b10, 25, 18};
    vecs[5] = '{2'b11, 18, 1};
    vecs[6] = '{2'b11, 287, 287};

    rst_n = 1'b0; din = 1'b0; din_vld = 1'b0; din_symb_cnt = 8'd0;
    din_Map_Type = 2'b00; dout_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_din_rdy", din_rdy, 1'b0);
    check("reset_dout_vld", dout_vld, 1'b0);
    check("reset_dout", dout, 1'b0);
    check("reset_symb", dout_symb_cnt, 8'd0);
    check("reset_map", dout_Map_Type, 2'b00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_reset", din_rdy, 1'b1);

    // One-hot vectors: hand-derived output position of the single 1.
    for (int i = 0; i < 7; i++) begin
      cap_q.delete();
      bits = '0;
      bits[vecs[i].one_j] = 1'b1;
      n = ncbps_tb(vecs[i].map);
      send_symbol(vecs[i].map, 8'(i), bits, n, 0, 0, 1);
      check("latency_vld", dout_vld, 1'b1);
      wait_drain("vec_drain");
      ones = 0; pos = -1;
      for (int k = 0; k < cap_q.size(); k++) if (cap_q[k]) begin ones++; pos = k; end
      check("vec_count", cap_q.size(), n);
      check("vec_ones", ones, 1);
      check("vec_pos", pos, vecs[i].exp_k);
    end

    // 64QAM ramp-style pattern against the model.
    for (int j = 0; j < 288; j++) bits[j] = ((j % 3) == 0) ^ ((j / 16) % 2 == 1);
    send_symbol(2'b11, 8'd9, bits, 288, 0, 0, 1);
    wait_drain("ramp_drain");

    // Back-to-back streaming must never stall the input.
    cap_q.delete();
    stall_cnt = 0;
    for (int s = 0; s < 3; s++) send_symbol(2'b10, 8'(20 + s), rand_bits(), 192, 0, 0, 1);
    wait_drain("stream_drain");
    check("stream_stalls", stall_cnt, 0);
    check("stream_count", cap_q.size(), 576);

    // Back-pressure: two QPSK symbols fill both banks.
    cap_q.delete();
    rdy_mode = 2;
    @(posedge clk); #1;
    send_symbol(2'b01, 8'd1, rand_bits(), 96, 0, 0, 1);
    send_symbol(2'b01, 8'd2, rand_bits(), 96, 0, 0, 1);
    check("bp_rdy_low", din_rdy, 1'b0);
    check("bp_vld_high", dout_vld, 1'b1);
    fork
      send_symbol(2'b01, 8'd3, rand_bits(), 96, 0, 0, 1);
      begin
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_out", cap_q.size(), 0);
        check("bp_rdy_still_low", din_rdy, 1'b0);
        rdy_mode = 0;
      end
    join
    wait_drain("bp_drain");
    check("bp_count", cap_q.size(), 288);

    // Tags follow each bank; mid-symbol Map_Type/symb_cnt changes ignored.
    cap_q.delete();
    rdy_mode = 1;
    send_symbol(2'b10, 8'd5, rand_bits(), 192, 0, 1, 1);
    send_symbol(2'b00, 8'd6, rand_bits(), 48, 0, 1, 1);
    wait_drain("tag_drain");
    check("tag_count", cap_q.size(), 240);

    // Random mixed symbols with gaps on both sides.
    cap_q.delete();
    total = 0;
    for (int s = 0; s < 20; s++) begin
      m = 2'($urandom_range(0, 3));
      total += ncbps_tb(m);
      send_symbol(m, 8'(100 + s), rand_bits(), ncbps_tb(m), 1, 1, 1);
    end
    wait_drain("rand_drain");
    check("rand_count", cap_q.size(), total);

    // Reset mid-fill.
    rdy_mode = 0;
    send_symbol(2'b11, 8'd50, rand_bits(), 100, 0, 0, 0);
    do_reset();
    send_symbol(2'b10, 8'd51, rand_bits(), 192, 0, 0, 1);
    wait_drain("fill_rst_drain");
    check("fill_rst_count", cap_q.size(), 192);

    // Reset mid-drain.
    cap_q.delete();
    send_symbol(2'b00, 8'd60, rand_bits(), 48, 0, 0, 1);
    pos = 0;
    while (cap_q.size() < 20) begin
      @(posedge clk); #1;
      pos++;
      if (pos > 1000) timeout_abort("drain_rst_wait");
    end
    #1;
    do_reset();
    send_symbol(2'b01, 8'd61, rand_bits(), 96, 0, 0, 1);
    wait_drain("drain_rst_drain");
    check("drain_rst_count", cap_q.size(), 96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
